sgm_path_aggregator: RTL
========================

SGM_PATH_AGGREGATOR -- requirements
Module: sgm_path_aggregator

Interface
REQ-001 The block SHALL have parameter DISPARITY_RANGE, default 8: number of disparity hypotheses per pixel.
REQ-002 The block SHALL have parameter COST_BITS, default 8: width of each input matching cost.
REQ-003 The block SHALL have parameter AGG_BITS, default 10: width of each aggregated path cost.
REQ-004 The block SHALL have parameter P1, default 10: penalty for a disparity change of 1.
REQ-005 The block SHALL have parameter P2, default 120: penalty for a disparity change greater than 1.
REQ-006 The block SHALL have one clock and a synchronous active-high reset, with these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- de_in  in  1  pixel valid.
- h_sync_in  in  1  horizontal sync.
- v_sync_in  in  1  vertical sync.
- cost_in  in  COST_BITS*DISPARITY_RANGE  packed costs; disparity d at bits [COST_BITS*d +: COST_BITS].
- de_out  out  1  de_in delayed by the pipeline.
- h_sync_out  out  1  h_sync_in delayed by the pipeline.
- v_sync_out  out  1  v_sync_in delayed by the pipeline.
- path_cost_out  out  AGG_BITS*DISPARITY_RANGE  aggregated costs L, same packing as cost_in.
- disparity_out  out  clog2(DISPARITY_RANGE)  index of the minimum L.

Function
REQ-007 Stage 1 SHALL register cost_in, de_in, h_sync_in and v_sync_in.
REQ-008 Stage 2 SHALL compute the left-to-right path cost L(p,d) = C(p,d) + min(Lp(d), Lp(d-1)+P1, Lp(d+1)+P1, minLp+P2) - minLp, where Lp is the previous valid pixel's L and minLp is its minimum over d.
REQ-009 At d=0 the Lp(d-1) term SHALL be omitted, and at d=DISPARITY_RANGE-1 the Lp(d+1) term SHALL be omitted.
REQ-010 Stage 2 SHALL complete within one clock, so that a new pixel can be accepted every cycle with no stall and no backpressure.
REQ-011 minLp SHALL be held in a register alongside Lp and SHALL NOT be recomputed in the feedback path.
REQ-012 All intermediate sums SHALL be at least AGG_BITS+1 wide, and the final L SHALL saturate at 2^AGG_BITS-1.
REQ-013 With the default parameters L SHALL never exceed 255+P2 = 375, so saturation never triggers.
REQ-014 Line start: a first_pix flag SHALL be set whenever the registered de is low; for the first valid pixel after that, L SHALL equal C zero-extended, and first_pix SHALL then clear.
REQ-015 While the registered de is low, Lp and minLp SHALL hold their values, and the stage-2 output register SHALL load zero.
REQ-016 Stage 3 SHALL register path_cost_out and disparity_out, where disparity_out is the argmin of L; on a tie the lowest index wins.
REQ-017 Total latency from input to output SHALL be exactly 3 cycles for data, de, h_sync and v_sync alike.
REQ-018 When de_out is low, path_cost_out and disparity_out SHALL be 0.
REQ-019 v_sync SHALL have no effect on aggregation state beyond its effect through de.

Reset
REQ-020 While rst is high at a clock edge, all pipeline registers, Lp and minLp SHALL be cleared to 0, first_pix SHALL be set to 1, and all outputs SHALL be 0.
REQ-021 If rst is asserted mid-line, the first valid pixel after rst deasserts SHALL be treated as a line start.
REQ-022 Outputs SHALL be valid again 3 cycles after the first de_in accepted following reset.

Structure
REQ-023 DISPARITY_RANGE, COST_BITS, AGG_BITS, P1, P2 defaults and the clog2 function SHALL live in the shared sgm parameter include file used by all SGM stages.
REQ-024 The stage-3 minimum search SHALL instantiate the existing argmin sub-module with WIDTH=AGG_BITS and INPUTS=DISPARITY_RANGE.
REQ-025 The stage-2 minimum (minLp) SHALL be computed by a second instance of argmin, using its min_value output.
REQ-026 The design SHALL be 120-400 lines of RTL with no other sub-modules.

Verification
REQ-027 Line start: de low then high; pixel 1 costs all 5 except d3=0 -> 3 cycles later L=[5,5,5,0,5,5,5,5] and disparity_out=3.
REQ-028 Steady state: pixel 2 costs all 0, following pixel 1 above -> L=[5,5,5,0,5,5,5,5] and disparity_out=3.
REQ-029 Large jump: previous L has 0 at d0 and 200 elsewhere; next costs all 0 -> L(d1)=10, L(d2..7)=120, L(d0)=0, disparity_out=0.
REQ-030 Saturation bound: costs of 255 on every d for 100 consecutive pixels -> every L=255, with no wrap.
REQ-031 Tie: equal costs on all d -> disparity_out=0.
REQ-032 Reset mid-line: assert rst for 1 cycle during a line -> outputs 0, and the next valid pixel gives L=C.
REQ-033 Sync alignment: de_out, h_sync_out and v_sync_out SHALL equal the inputs delayed by exactly 3 cycles over a full 64x64 frame.

Source files
------------

// File: rtl/sgm_path_aggregator_pkg.sv
// Shared SGM parameter defaults and helpers used by every SGM stage.
package sgm_path_aggregator_pkg;

    localparam int SGM_DISPARITY_RANGE = 8;
    localparam int SGM_COST_BITS       = 8;
    localparam int SGM_AGG_BITS        = 10;
    localparam int SGM_P1              = 10;
    localparam int SGM_P2              = 120;

    // Index width for n items; never below 1 so a single-entry range still has a port.
    function automatic int sgm_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sgm_path_aggregator_argmin.sv
// Combinational minimum search over a packed vector; ties resolve to the lowest index.
module sgm_path_aggregator_argmin
    import sgm_path_aggregator_pkg::*;
#(
    parameter int WIDTH  = SGM_AGG_BITS,
    parameter int INPUTS = SGM_DISPARITY_RANGE
) (
    input  logic [WIDTH*INPUTS-1:0]         values,
    output logic [WIDTH-1:0]                min_value,
    output logic [sgm_clog2(INPUTS)-1:0]    min_index
);

    localparam int IDX_BITS = sgm_clog2(INPUTS);

    logic [WIDTH-1:0] val [INPUTS];

    for (genvar gi = 0; gi < INPUTS; gi++) begin : g_unpack
        assign val[gi] = values[gi*WIDTH +: WIDTH];
    end

    // Strict less-than keeps the earliest index on equal values.
    always_comb begin
        min_value = val[0];
        min_index = '0;
        for (int i = 1; i < INPUTS; i++) begin
            if (val[i] < min_value) begin
                min_value = val[i];
                min_index = IDX_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/sgm_path_aggregator.sv
// Left-to-right SGM path cost aggregation: register inputs, one-cycle path update, argmin output.
module sgm_path_aggregator
    import sgm_path_aggregator_pkg::*;
#(
    parameter int DISPARITY_RANGE = SGM_DISPARITY_RANGE,
    parameter int COST_BITS       = SGM_COST_BITS,
    parameter int AGG_BITS        = SGM_AGG_BITS,
    parameter int P1              = SGM_P1,
    parameter int P2              = SGM_P2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  de_in,
    input  logic                                  h_sync_in,
    input  logic                                  v_sync_in,
    input  logic [COST_BITS*DISPARITY_RANGE-1:0]  cost_in,
    output logic                                  de_out,
    output logic                                  h_sync_out,
    output logic                                  v_sync_out,
    output logic [AGG_BITS*DISPARITY_RANGE-1:0]   path_cost_out,
    output logic [sgm_clog2(DISPARITY_RANGE)-1:0] disparity_out
);

    localparam int IDX_BITS = sgm_clog2(DISPARITY_RANGE);
    // Two guard bits hold Lp+P2 without wrap for any P2 below 2^(AGG_BITS+1).
    localparam int SUM_BITS = AGG_BITS + 2;
    localparam logic [SUM_BITS-1:0] P1_EXT  = SUM_BITS'(P1);
    localparam logic [SUM_BITS-1:0] P2_EXT  = SUM_BITS'(P2);
    localparam logic [AGG_BITS-1:0] L_MAX   = '1;
    localparam logic [SUM_BITS-1:0] SAT_MAX = SUM_BITS'(L_MAX);

    // Stage 1
    logic [COST_BITS*DISPARITY_RANGE-1:0] cost_s1_reg;
    logic de_s1_reg, hs_s1_reg, vs_s1_reg;

    // Stage 2 and path state
    logic [AGG_BITS*DISPARITY_RANGE-1:0] lp_reg;
    logic [AGG_BITS-1:0]                 min_lp_reg;
    logic                                first_pix_reg;
    logic [AGG_BITS*DISPARITY_RANGE-1:0] l_s2_reg;
    logic de_s2_reg, hs_s2_reg, vs_s2_reg;

    logic [AGG_BITS*DISPARITY_RANGE-1:0] l_next;
    logic [AGG_BITS-1:0]                 min_next;
    logic [IDX_BITS-1:0]                 lp_idx_unused;
    logic [AGG_BITS-1:0]                 out_min_unused;
    logic [IDX_BITS-1:0]                 disp_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            cost_s1_reg <= '0;
            de_s1_reg   <= 1'b0;
            hs_s1_reg   <= 1'b0;
            vs_s1_reg   <= 1'b0;
        end else begin
            cost_s1_reg <= cost_in;
            de_s1_reg   <= de_in;
            hs_s1_reg   <= h_sync_in;
            vs_s1_reg   <= v_sync_in;
        end
    end

    for (genvar gi = 0; gi < DISPARITY_RANGE; gi++) begin : g_path
        logic [SUM_BITS-1:0] c_ext, same_ext, left_ext, right_ext, jump_ext;
        logic [SUM_BITS-1:0] best, path_sum, l_full;

        assign c_ext    = SUM_BITS'(cost_s1_reg[gi*COST_BITS +: COST_BITS]);
        assign same_ext = SUM_BITS'(lp_reg[gi*AGG_BITS +: AGG_BITS]);
        assign jump_ext = SUM_BITS'(min_lp_reg) + P2_EXT;

        // Edge disparities drop the missing neighbour by offering an unbeatable candidate.
        if (gi > 0) begin : g_left
            assign left_ext = SUM_BITS'(lp_reg[(gi-1)*AGG_BITS +: AGG_BITS]) + P1_EXT;
        end else begin : g_no_left
            assign left_ext = '1;
        end

        if (gi < DISPARITY_RANGE - 1) begin : g_right
            assign right_ext = SUM_BITS'(lp_reg[(gi+1)*AGG_BITS +: AGG_BITS]) + P1_EXT;
        end else begin : g_no_right
            assign right_ext = '1;
        end

        // Every candidate is >= minLp, so subtracting before adding C cannot underflow.
        always_comb begin
            best = same_ext;
            if (left_ext < best) begin
                best = left_ext;
            end
            if (right_ext < best) begin
                best = right_ext;
            end
            if (jump_ext < best) begin
                best = jump_ext;
            end
            path_sum = c_ext + (best - SUM_BITS'(min_lp_reg));
            l_full   = first_pix_reg ? c_ext : path_sum;
        end

        assign l_next[gi*AGG_BITS +: AGG_BITS] =
            (l_full > SAT_MAX) ? L_MAX : l_full[AGG_BITS-1:0];
    end

    // minLp for the next pixel is taken from the freshly computed L and stored with it.
    sgm_path_aggregator_argmin #(
        .WIDTH  (AGG_BITS),
        .INPUTS (DISPARITY_RANGE)
    ) u_min_lp (
        .values    (l_next),
        .min_value (min_next),
        .min_index (lp_idx_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lp_reg        <= '0;
            min_lp_reg    <= '0;
            first_pix_reg <= 1'b1;
            l_s2_reg      <= '0;
            de_s2_reg     <= 1'b0;
            hs_s2_reg     <= 1'b0;
            vs_s2_reg     <= 1'b0;
        end else begin
            de_s2_reg <= de_s1_reg;
            hs_s2_reg <= hs_s1_reg;
            vs_s2_reg <= vs_s1_reg;
            if (de_s1_reg) begin
                lp_reg        <= l_next;
                min_lp_reg    <= min_next;
                first_pix_reg <= 1'b0;
                l_s2_reg      <= l_next;
            end else begin
                first_pix_reg <= 1'b1;
                l_s2_reg      <= '0;
            end
        end
    end

    sgm_path_aggregator_argmin #(
        .WIDTH  (AGG_BITS),
        .INPUTS (DISPARITY_RANGE)
    ) u_out_min (
        .values    (l_s2_reg),
        .min_value (out_min_unused),
        .min_index (disp_s3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            de_out        <= 1'b0;
            h_sync_out    <= 1'b0;
            v_sync_out    <= 1'b0;
            path_cost_out <= '0;
            disparity_out <= '0;
        end else begin
            de_out        <= de_s2_reg;
            h_sync_out    <= hs_s2_reg;
            v_sync_out    <= vs_s2_reg;
            path_cost_out <= de_s2_reg ? l_s2_reg : '0;
            disparity_out <= de_s2_reg ? disp_s3 : '0;
        end
    end

endmodule
